// File: rtl/latch_cmp_sar_ctrl_if.sv
// Bus between the SAR controller and its analog front end (R-2R DAC and latch comparator).
// The controller takes the master modport. The comparator/DAC side or a bench takes the slave modport.
interface latch_cmp_sar_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic             cmp_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  start,
    input  cmp_in,
    output dac_code,
    output cmp_en,
    output busy,
    output done,
    output result
  );

  modport slave (
    output start,
    output cmp_in,
    input  dac_code,
    input  cmp_en,
    input  busy,
    input  done,
    input  result
  );
endinterface

// File: rtl/latch_cmp_sar_ctrl.sv
// Successive-approximation controller for the latch comparator tile.
// It walks the trial code down from the MSB and drives each trial code to the external R-2R DAC.
// After a settling window it keeps or clears each bit from the comparator decision.
// The finished code is published on result together with a one-cycle done pulse.
//
// Build option LATCH_CMP_SYNC_EN: when defined, cmp_in passes through a two-flop synchronizer.
// Each bit's settling window then grows by two cycles. Define it whenever the comparator output
// is not clocked by clk. When undefined, cmp_in is used directly in the decide cycle.
module latch_cmp_sar_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  latch_cmp_sar_ctrl_if.master bus
);

`ifdef LATCH_CMP_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  // Cycles spent in SETTLE per bit: DAC settling plus synchronizer latency
  localparam int WAIT_CYC = SETTLE + SYNC_LAT;
  localparam int CNT_W    = $clog2(WAIT_CYC + 1);
  localparam int IDX_W    = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] ONE_HOT_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_CODE    = ONE_HOT_LSB << (WIDTH - 1);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECIDE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] result_q;
  logic             cmp_en_q;
  logic             busy_q;
  logic             done_q;

  logic             cmp_bit;
  logic [WIDTH-1:0] trial_mask;
  logic [WIDTH-1:0] kept_code;
  logic [WIDTH-1:0] next_trial;

`ifdef LATCH_CMP_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer that brings the asynchronous comparator decision into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bus.cmp_in;
      sync_q2 <= sync_q1;
    end
  end

  assign cmp_bit = sync_q2;
`else
  assign cmp_bit = bus.cmp_in;
`endif

  // Decide-cycle arithmetic: drop the bit under trial if the comparator says Vin is below it,
  // then put the next lower bit on trial
  always_comb begin
    trial_mask = ONE_HOT_LSB << bit_idx;
    kept_code  = cmp_bit ? dac_q : (dac_q & ~trial_mask);
    next_trial = kept_code | (trial_mask >> 1);
  end

  // Conversion sequencer; every output is registered so the DAC pins never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      wait_cnt <= '0;
      dac_q    <= '0;
      result_q <= '0;
      cmp_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_SETTLE;
            dac_q    <= MSB_CODE;
            bit_idx  <= MSB_IDX;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
            cmp_en_q <= 1'b1;
          end
        end

        ST_SETTLE: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_DECIDE;
          end
        end

        ST_DECIDE: begin
          if (bit_idx != '0) begin
            dac_q    <= next_trial;
            bit_idx  <= bit_idx - IDX_W'(1);
            wait_cnt <= '0;
            state    <= ST_SETTLE;
          end else begin
            dac_q    <= kept_code;
            busy_q   <= 1'b0;
            cmp_en_q <= 1'b0;
            state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          result_q <= dac_q;
          done_q   <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          cmp_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dac_code = dac_q;
  assign bus.result   = result_q;
  assign bus.cmp_en   = cmp_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_latch_cmp_sar_ctrl.sv
// Directed bench for latch_cmp_sar_ctrl with an ideal comparator model (cmp_in = vin_code >= dac_code).
// Expected latencies follow LATCH_CMP_SYNC_EN in the same way as the design build.
module tb_latch_cmp_sar_ctrl;

`ifdef LATCH_CMP_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
  localparam int LAT    = WIDTH * (SETTLE + SYNC_LAT + 1) + 1;
  localparam int PERIOD = LAT + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vin_code;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] seq [16];
  int         seq_len;
  logic [7:0] exp_seq [8];

  latch_cmp_sar_ctrl_if #(.WIDTH(WIDTH)) bus ();

  latch_cmp_sar_ctrl #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Ideal comparator: keep the bit whenever the input is at or above the DAC level
  assign bus.cmp_in = (vin_code >= bus.dac_code);

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One conversion from a one-cycle start pulse, with an optional extra start pulse at cycle pulse_at
  task automatic applyStimulus(input logic [7:0] vin, input int pulse_at,
                               output int lat, output logic [7:0] res);
    vin_code = vin;
    lat      = -1;
    res      = '0;
    for (int i = 0; i < 16; i++) seq[i] = '0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seq[0]  = bus.dac_code;
    seq_len = 1;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      bus.start = (n == pulse_at);
      if (bus.dac_code != seq[seq_len-1] && seq_len < 16) begin
        seq[seq_len] = bus.dac_code;
        seq_len++;
      end
      if (bus.done) begin
        lat = n;
        res = bus.result;
      end
    end
    bus.start = 1'b0;
  endtask

  // Verifies the done pulse lasts one cycle and that the controller then stays idle
  task automatic checkAfterDone(input string tag);
    int busy_seen;
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_drop"}, bus.done, 0);
    busy_seen = 0;
    repeat (3) begin
      busy_seen = busy_seen | bus.busy;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_busy_low"}, busy_seen, 0);
  endtask

  initial begin
    int         lat;
    logic [7:0] res;
    int         acc;
    int         done_cnt;
    int         done_at [3];

    exp_seq   = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    rst_n     = 1'b0;
    bus.start = 1'b0;
    vin_code  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dac_code", bus.dac_code, 0);
    checkOutput("rst_result",   bus.result,   0);
    checkOutput("rst_busy",     bus.busy,     0);
    checkOutput("rst_done",     bus.done,     0);
    checkOutput("rst_cmp_en",   bus.cmp_en,   0);

    // Idle for 100 cycles with start low
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      acc = acc | bus.dac_code | bus.result | bus.busy | bus.done | bus.cmp_en;
    end
    checkOutput("idle_outputs", acc, 0);

    // 0xA5 conversion with trial-code trace
    vin_code = 8'hA5;
    #1;
    applyStimulus(8'hA5, 0, lat, res);
    checkOutput("a5_latency", lat, LAT);
    checkOutput("a5_result",  res, 8'hA5);
    checkOutput("a5_seq_len", seq_len, 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("a5_seq_%0d", i), seq[i], exp_seq[i]);
    checkAfterDone("a5");

    // All-zero input
    applyStimulus(8'h00, 0, lat, res);
    checkOutput("zero_latency", lat, LAT);
    checkOutput("zero_result",  res, 8'h00);
    checkAfterDone("zero");

    // Full-scale input, plus a stray start pulse mid-conversion that must not queue
    applyStimulus(8'hFF, 10, lat, res);
    checkOutput("ff_latency", lat, LAT);
    checkOutput("ff_result",  res, 8'hFF);
    checkAfterDone("ff");

    // Start held high gives back-to-back conversions
    vin_code = 8'h3C;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 0; n <= 3 * PERIOD + 20 && done_cnt < 3; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_at[done_cnt] = n;
        checkOutput($sformatf("b2b_result_%0d", done_cnt), bus.result, 8'h3C);
        done_cnt++;
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_done_count", done_cnt, 3);
    if (done_cnt == 3) begin
      checkOutput("b2b_first",   done_at[0], LAT);
      checkOutput("b2b_period1", done_at[1] - done_at[0], PERIOD);
      checkOutput("b2b_period2", done_at[2] - done_at[1], PERIOD);
    end
    repeat (2) @(posedge clk);

    // Asynchronous reset at cycle 20 of a conversion
    vin_code = 8'h77;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    checkOutput("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_dac_code", bus.dac_code, 0);
    checkOutput("arst_result",   bus.result,   0);
    checkOutput("arst_busy",     bus.busy,     0);
    checkOutput("arst_done",     bus.done,     0);
    checkOutput("arst_cmp_en",   bus.cmp_en,   0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h5A, 0, lat, res);
    checkOutput("post_rst_latency", lat, LAT);
    checkOutput("post_rst_result",  res, 8'h5A);
    checkAfterDone("post_rst");

    // 0x81 conversion
    applyStimulus(8'h81, 0, lat, res);
    checkOutput("x81_latency", lat, LAT);
    checkOutput("x81_result",  res, 8'h81);
    checkAfterDone("x81");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
